// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the wishbone scratchpad slave
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_t;

    localparam logic [3:0] WB_SEL_BYTE = 4'b0001;
    localparam logic [3:0] WB_SEL_HALF = 4'b0011;
    localparam logic [3:0] WB_SEL_WORD = 4'b1111;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] wb_lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  sel
    );
        logic [31:0] merged;
        merged = old_word;
        for (int lane = 0; lane < 4; lane++) begin
            if (sel[lane]) begin
                merged[8*lane +: 8] = new_word[8*lane +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/sram_byte_en.sv
// rtl/sram_byte_en.sv - word SRAM with per-byte write enables and asynchronous read
module sram_byte_en
    import wb_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    sel,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wb_lane_merge(mem[addr], wdata, sel);
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/wb_slave_sram_ws.sv
// rtl/wb_slave_sram_ws.sv - wishbone classic slave serving a scratchpad SRAM with wait states
module wb_slave_sram_ws
    import wb_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o
);

    localparam int IDX_W = $clog2(DEPTH);

    wb_slv_state_t     state;
    wb_slv_state_t     state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    logic [ADDR_W-3:0] req_word;
    logic              req_we;
    logic [3:0]        req_sel;
    logic [31:0]       req_dat;

    logic [ADDR_W-3:0] eff_word;
    logic              eff_we;
    logic              eff_oor;
    logic              req_hit;
    logic              sram_we;
    logic [31:0]       sram_rdata;
    logic              unused_adr_bits;

    assign req_hit         = wb_cyc_i & wb_stb_i;
    assign unused_adr_bits = ^wb_adr_i[1:0];

    // With zero wait states the response is set up on the capture edge itself,
    // so the live bus address is used in IDLE and the captured one afterwards.
    assign eff_word = (state == IDLE) ? wb_adr_i[ADDR_W-1:2] : req_word;
    assign eff_we   = (state == IDLE) ? wb_we_i : req_we;
    assign eff_oor  = (eff_word >= (ADDR_W-2)'(DEPTH));

    assign sram_we  = (state == RESP) & req_we & ~eff_oor;

    sram_byte_en #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_sram (
        .clk   (clk),
        .addr  (eff_word[IDX_W-1:0]),
        .we    (sram_we),
        .sel   (req_sel),
        .wdata (req_dat),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_hit) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_STATES - 1);
                    end
                end
            end
            WAIT: begin
                if (!wb_cyc_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            req_word <= '0;
            req_we   <= 1'b0;
            req_sel  <= 4'd0;
            req_dat  <= 32'd0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= 32'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wb_ack_o <= (state_nxt == RESP) & ~eff_oor;
            wb_err_o <= (state_nxt == RESP) & eff_oor;
            if (state == IDLE && req_hit) begin
                req_word <= wb_adr_i[ADDR_W-1:2];
                req_we   <= wb_we_i;
                req_sel  <= wb_sel_i;
                req_dat  <= wb_dat_i;
            end
            // Read data lands with the termination pulse and holds until the next read or err.
            if (state_nxt == RESP) begin
                if (eff_oor) begin
                    wb_dat_o <= 32'd0;
                end else if (!eff_we) begin
                    wb_dat_o <= sram_rdata;
                end
            end
        end
    end

    assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_slave_sram_ws.sv
// tb/tb_wb_slave_sram_ws.sv - self-checking bench for wb_slave_sram_ws at 1, 3 and 0 wait states
module tb_wb_slave_sram_ws;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [2:0]       cyc, stb, we, ack, err, rty;
    logic [2:0][31:0] adr, wdat, rdat;
    logic [2:0][3:0]  sel;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_m [3][128];
    logic [31:0] hold_m [3];
    longint      term_time;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    wb_slave_sram_ws #(.DEPTH(128), .WAIT_STATES(1), .ADDR_W(32)) u_ws1 (
        .clk(clk), .reset_n(reset_n), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]));

    wb_slave_sram_ws #(.DEPTH(128), .WAIT_STATES(3), .ADDR_W(32)) u_ws3 (
        .clk(clk), .reset_n(reset_n), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]));

    wb_slave_sram_ws #(.DEPTH(128), .WAIT_STATES(0), .ADDR_W(32)) u_ws0 (
        .clk(clk), .reset_n(reset_n), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]), .wb_we_i(we[2]),
        .wb_adr_i(adr[2]), .wb_sel_i(sel[2]), .wb_dat_i(wdat[2]), .wb_dat_o(rdat[2]),
        .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_rty_o(rty[2]));

    function automatic int ws(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // One master transfer; returns what the termination cycle looked like.
    task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input bit pulse,
                       output logic t_ack, output logic t_err, output logic [31:0] t_dat,
                       output int lat);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; sel[k] = s; wdat[k] = d;
        @(posedge clk);
        lat = 0; t_ack = 1'b0; t_err = 1'b0; t_dat = 32'd0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ack[k] | err[k]) begin
                lat = n; t_ack = ack[k]; t_err = err[k]; t_dat = rdat[k];
                term_time = $time;
                break;
            end
            we[k] = 1'($urandom); adr[k] = $urandom; sel[k] = 4'($urandom); wdat[k] = $urandom;
        end
        cyc[k] = 1'b0; stb[k] = 1'b0;
        if (pulse) begin
            @(negedge clk);
            chk($sformatf("pulse_width[%0d]", k), {30'd0, ack[k], err[k]}, 32'd0);
        end
    endtask

    task automatic model_update(input int k, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d, output logic [31:0] e_dat);
        int idx;
        idx = int'(a[31:2]);
        if (a[31:2] >= 30'd128) begin
            e_dat = 32'd0;
        end else if (!w) begin
            e_dat = mem_m[k][idx];
        end else begin
            e_dat = hold_m[k];
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mem_m[k][idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        hold_m[k] = e_dat;
    endtask

    task automatic apply(input int k, input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input bit pulse);
        logic        oor, ta, te;
        logic [31:0] td, e_dat;
        int          lat;
        oor = (a[31:2] >= 30'd128);
        model_update(k, w, a, s, d, e_dat);
        txn(k, w, a, s, d, pulse, ta, te, td, lat);
        chk($sformatf("ack[%0d] adr %h", k, a), {31'd0, ta}, {31'd0, ~oor});
        chk($sformatf("err[%0d] adr %h", k, a), {31'd0, te}, {31'd0, oor});
        chk($sformatf("dat[%0d] adr %h", k, a), td, e_dat);
        chk($sformatf("latency[%0d]", k), lat, ws(k) + 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic        ta, te, seen;
        logic [31:0] td, e_dat, a;
        int          lat;
        longint      t_prev;

        cyc = '0; stb = '0; we = '0; adr = '0; wdat = '0; sel = '0;
        hold_m = '{default: 32'd0};
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_ack[%0d]", k), {31'd0, ack[k]}, 32'd0);
            chk($sformatf("reset_err[%0d]", k), {31'd0, err[k]}, 32'd0);
            chk($sformatf("reset_dat[%0d]", k), rdat[k], 32'd0);
            chk($sformatf("reset_rty[%0d]", k), {31'd0, rty[k]}, 32'd0);
        end
        reset_n = 1'b1;

        for (int i = 0; i < 128; i++) begin
            apply(0, 1'b1, 32'(i * 4), 4'hF, 32'(i) * 32'h01010101, 1'b0);
        end

        vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 4'h2, 32'h0000AA00, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 32'h0000_0010, 4'h1, 32'h0,        1'b0, 32'hDEADAAEF};
        vecs[4]  = '{1'b0, 32'h0000_0200, 4'hF, 32'h0,        1'b1, 32'h0000_0000};
        vecs[5]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF};
        vecs[6]  = '{1'b1, 32'h0000_01FC, 4'hF, 32'h12345678, 1'b0, 32'hDEADAAEF};
        vecs[7]  = '{1'b1, 32'h0000_01FC, 4'h0, 32'hFFFFFFFF, 1'b0, 32'hDEADAAEF};
        vecs[8]  = '{1'b0, 32'h0000_01FC, 4'hF, 32'h0,        1'b0, 32'h12345678};
        vecs[9]  = '{1'b1, 32'h0000_0200, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_01FD, 4'hF, 32'h0,        1'b0, 32'h12345678};
        vecs[11] = '{1'b1, 32'h0000_0020, 4'hC, 32'hAABBCCDD, 1'b0, 32'h12345678};
        vecs[12] = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,        1'b0, 32'hAABB0808};
        vecs[13] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,        1'b1, 32'h0000_0000};
        vecs[14] = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,        1'b0, 32'hDEADAAEF};

        for (int i = 0; i < 15; i++) begin
            model_update(0, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, e_dat);
            txn(0, vecs[i].w, vecs[i].a, vecs[i].s, vecs[i].d, 1'b1, ta, te, td, lat);
            chk($sformatf("vec%0d_ack", i), {31'd0, ta}, {31'd0, ~vecs[i].exp_err});
            chk($sformatf("vec%0d_err", i), {31'd0, te}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_dat", i), td, vecs[i].exp_dat);
            chk($sformatf("vec%0d_latency", i), lat, 2);
        end

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom;
                if (a[31:2] < 30'd128) a[9] = 1'b1;
            end else begin
                a = $urandom_range(0, 511);
            end
            apply(0, 1'($urandom), a, 4'($urandom), $urandom, 1'($urandom));
        end

        apply(1, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b1);
        apply(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; wdat[1] = 32'h55667788;
        @(posedge clk);
        @(negedge clk);
        stb[1] = 1'b0;
        @(negedge clk);
        cyc[1] = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ack[1] | err[1];
        end
        chk("abort_no_term", {31'd0, seen}, 32'd0);
        chk("abort_dat_hold", rdat[1], 32'h11223344);
        apply(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            apply(2, 1'b1, 32'(i * 4), 4'hF, 32'hA5000000 + 32'(i * 7), 1'b0);
        end
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            apply(2, 1'b0, 32'(i * 4), 4'hF, 32'h0, 1'b0);
            if (i > 0) chk($sformatf("b2b_spacing%0d", i), 32'(term_time - t_prev), 32'd20);
            t_prev = term_time;
        end

        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h40; sel[1] = 4'hF; wdat[1] = 32'h99999999;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midreset_ack", {31'd0, ack[1]}, 32'd0);
        chk("midreset_err", {31'd0, err[1]}, 32'd0);
        chk("midreset_dat", rdat[1], 32'd0);
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        hold_m = '{default: 32'd0};
        apply(1, 1'b0, 32'h40, 4'hF, 32'h0, 1'b1);

        chk("rty_all", {29'd0, rty}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
